// File: rtl/tdm_pkg.sv
// Shared TDM framing defaults and receiver state encoding.
package tdm_pkg;

    localparam int TDM_SLOTS     = 8;
    localparam int TDM_SLOT_BITS = 32;
    localparam int TDM_DATA_BITS = 24;

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        SYNC = 2'd1,
        RECV = 2'd2
    } tdm_state_t;

endpackage

// File: rtl/tdm_edge_det.sv
// bclk rising-edge detector in the mclk_in domain.
module tdm_edge_det (
    input  logic mclk_in,
    input  logic rst,
    input  logic i_bclk,
    output logic o_rise
);

    logic r_bclk;
    logic r_arm;

    // r_arm masks the first cycle after reset so a high bclk is not a rise
    always_ff @(posedge mclk_in or posedge rst) begin
        if (rst) begin
            r_bclk <= 1'b0;
            r_arm  <= 1'b0;
        end else begin
            r_bclk <= i_bclk;
            r_arm  <= 1'b1;
        end
    end

    assign o_rise = r_arm & i_bclk & ~r_bclk;

endmodule

// File: rtl/tdm_rx.sv
// TDM serial receiver: frame sync hunt, slot deserialisation, framing errors.
module tdm_rx
    import tdm_pkg::*;
#(
    parameter int SLOTS     = TDM_SLOTS,
    parameter int SLOT_BITS = TDM_SLOT_BITS,
    parameter int DATA_BITS = TDM_DATA_BITS
) (
    input  logic                     mclk_in,
    input  logic                     rst,
    input  logic                     bclk,
    input  logic                     wclk,
    input  logic                     tdm_in,
    output logic [DATA_BITS-1:0]     slot_data,
    output logic [$clog2(SLOTS)-1:0] slot_idx,
    output logic                     slot_valid,
    output logic                     frame_start,
    output logic                     err_frame
);

    localparam int BW = $clog2(SLOT_BITS);
    localparam int SW = $clog2(SLOTS);
    localparam logic [BW-1:0] LAST_BIT  = BW'(SLOT_BITS - 1);
    localparam logic [SW-1:0] LAST_SLOT = SW'(SLOTS - 1);

    tdm_state_t r_state;
    tdm_state_t w_state_nxt;

    logic [BW-1:0]        r_bit_cnt;
    logic [SW-1:0]        r_slot_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_data;
    logic [SW-1:0]        r_idx;
    logic                 r_valid;
    logic                 r_fs;
    logic                 r_err;

    logic                 w_rise;
    logic [BW-1:0]        w_bit_nxt;
    logic [SW-1:0]        w_slot_nxt;
    logic [DATA_BITS-1:0] w_shift_nxt;
    logic [DATA_BITS-1:0] w_shifted;
    logic                 w_last_bit;
    logic                 w_last_slot;
    logic                 w_data_bit;
    logic                 w_emit;
    logic                 w_err;

    tdm_edge_det u_edge (
        .mclk_in (mclk_in),
        .rst     (rst),
        .i_bclk  (bclk),
        .o_rise  (w_rise)
    );

    assign w_last_bit  = (r_bit_cnt == LAST_BIT);
    assign w_last_slot = (r_slot_cnt == LAST_SLOT);
    assign w_data_bit  = (int'(r_bit_cnt) < DATA_BITS);
    assign w_shifted   = {r_shift[DATA_BITS-2:0], tdm_in};

    always_ff @(posedge mclk_in or posedge rst) begin
        if (rst) begin
            r_state <= HUNT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_bit_nxt   = r_bit_cnt;
        w_slot_nxt  = r_slot_cnt;
        w_shift_nxt = r_shift;
        w_emit      = 1'b0;
        w_err       = 1'b0;
        if (w_rise) begin
            unique case (r_state)
                HUNT: begin
                    if (wclk) w_state_nxt = SYNC;
                end
                SYNC: begin
                    // one-bclk sync delay: this rise carries slot 0 bit 0
                    w_shift_nxt = w_shifted;
                    w_bit_nxt   = BW'(1);
                    w_slot_nxt  = '0;
                    w_state_nxt = RECV;
                end
                RECV: begin
                    if (wclk && !(w_last_bit && w_last_slot)) begin
                        w_err       = 1'b1;
                        w_state_nxt = SYNC;
                    end else begin
                        if (w_data_bit) w_shift_nxt = w_shifted;
                        if (w_last_bit) begin
                            w_emit     = 1'b1;
                            w_bit_nxt  = '0;
                            w_slot_nxt = w_last_slot ? '0 : r_slot_cnt + 1'b1;
                            if (w_last_slot && !wclk) begin
                                w_err       = 1'b1;
                                w_state_nxt = HUNT;
                            end
                        end else begin
                            w_bit_nxt = r_bit_cnt + 1'b1;
                        end
                    end
                end
                default: w_state_nxt = HUNT;
            endcase
        end
    end

    always_ff @(posedge mclk_in or posedge rst) begin
        if (rst) begin
            r_bit_cnt  <= '0;
            r_slot_cnt <= '0;
            r_shift    <= '0;
            r_data     <= '0;
            r_idx      <= '0;
            r_valid    <= 1'b0;
            r_fs       <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_bit_cnt  <= w_bit_nxt;
            r_slot_cnt <= w_slot_nxt;
            r_shift    <= w_shift_nxt;
            r_valid    <= w_emit;
            r_fs       <= w_emit && (r_slot_cnt == '0);
            r_err      <= w_err;
            if (w_emit) begin
                r_data <= w_shift_nxt;
                r_idx  <= r_slot_cnt;
            end
        end
    end

    assign slot_data   = r_data;
    assign slot_idx    = r_idx;
    assign slot_valid  = r_valid;
    assign frame_start = r_fs;
    assign err_frame   = r_err;

endmodule
